// File: rtl/uart_load_packer.sv
// -----------------------------------------------------------------------------
// uart_load_packer
//
// Sits behind the UART memory loader in the data_clk domain. Byte writes from
// the loader are paired into 16-bit little-endian words, queued in a small
// FIFO and handed to the memory arbiter over a req/ack handshake. The core is
// kept halted through 'hold' until the whole image has drained.
//
// Ports:
//   clk        data clock (shared with the loader)
//   rst        asynchronous reset, active-high
//   load_addr  [27:24] memory select, [23:0] byte address
//   load_we    loader write strobe; only its rising edge captures a byte
//   loading    high while the loader streams an image
//   load_data  byte to write, valid while load_we is high
//   mem_req    head FIFO word is valid (write request to arbiter)
//   mem_ack    arbiter accepted the head word this cycle
//   mem_sel    memory select of the head word
//   mem_addr   word address of the head word (byte address >> 1)
//   mem_wdata  head word; [7:0] even byte, [15:8] odd byte
//   mem_be     byte enables; [0] low byte, [1] high byte
//   hold       keep the core halted while anything is still in flight
//   done       one-cycle pulse when a load session has fully drained
//   overflow   sticky: a byte or word was dropped
// -----------------------------------------------------------------------------
module uart_load_packer #(
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] load_addr,
    input  logic        load_we,
    input  logic        loading,
    input  logic [7:0]  load_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [3:0]  mem_sel,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    output logic        hold,
    output logic        done,
    output logic        overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int EW    = 45;  // {sel[3:0], addr[22:0], data[15:0], be[1:0]}
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HALF   = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    // Pack one FIFO entry; the word address drops the byte-select bit.
    function automatic logic [EW-1:0] make_entry(
        input logic [3:0]  sel,
        input logic [23:0] byte_addr,
        input logic [15:0] data,
        input logic [1:0]  be
    );
        return {sel, byte_addr[23:1], data, be};
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic          load_we_q_r;
    logic [3:0]    held_sel_r;
    logic [23:0]   held_addr_r;
    logic [7:0]    held_byte_r;
    logic [3:0]    rep_sel_r;
    logic [23:0]   rep_addr_r;
    logic [7:0]    rep_byte_r;
    logic          session_r;
    logic          overflow_r;
    logic [EW-1:0] fifo_mem_r [DEPTH];
    logic [FIFO_AW:0] wptr_r;
    logic [FIFO_AW:0] rptr_r;

    logic          cap_s;
    logic [3:0]    in_sel_s;
    logic [23:0]   in_addr_s;
    logic          pair_hit_s;
    logic          push_s;
    logic [EW-1:0] push_entry_s;
    logic          held_from_in_s;
    logic          held_from_rep_s;
    logic          latch_rep_s;
    logic          drop_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          done_s;
    logic [EW-1:0] head_s;

    assign cap_s      = load_we & ~load_we_q_r;
    assign in_sel_s   = load_addr[27:24];
    assign in_addr_s  = load_addr[23:0];
    // held address is always even, so +1 never carries and never reaches sel
    assign pair_hit_s = (in_sel_s == held_sel_r) && (in_addr_s == (held_addr_r + 24'd1));

    // Strobe edge register: a held load_we captures only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_we_q_r <= 1'b0;
        end else begin
            load_we_q_r <= load_we;
        end
    end

    // Packer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Packer next-state logic. HALF flushes whenever loading is low and no
    // byte arrives, which also covers a fall that coincides with a capture
    // or with a REPLAY that lands in HALF.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (cap_s && !in_addr_s[0]) begin
                    state_s = ST_HALF;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_HALF: begin
                if (cap_s) begin
                    if (pair_hit_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_REPLAY;
                    end
                end else if (!loading) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_HALF;
                end
            end
            ST_REPLAY: begin
                if (rep_addr_r[0]) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_HALF;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // Packer output logic: FIFO push word and holding-register load enables.
    always_comb begin
        push_s          = 1'b0;
        push_entry_s    = {EW{1'b0}};
        held_from_in_s  = 1'b0;
        held_from_rep_s = 1'b0;
        latch_rep_s     = 1'b0;
        drop_s          = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (cap_s) begin
                    if (!in_addr_s[0]) begin
                        held_from_in_s = 1'b1;
                    end else begin
                        push_s       = 1'b1;
                        push_entry_s = make_entry(in_sel_s, in_addr_s, {load_data, 8'h00}, 2'b10);
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
            ST_HALF: begin
                if (cap_s) begin
                    push_s = 1'b1;
                    if (pair_hit_s) begin
                        push_entry_s = make_entry(held_sel_r, held_addr_r, {load_data, held_byte_r}, 2'b11);
                    end else begin
                        push_entry_s = make_entry(held_sel_r, held_addr_r, {8'h00, held_byte_r}, 2'b01);
                        latch_rep_s  = 1'b1;
                    end
                end else if (!loading) begin
                    push_s       = 1'b1;
                    push_entry_s = make_entry(held_sel_r, held_addr_r, {8'h00, held_byte_r}, 2'b01);
                end else begin
                    push_s = 1'b0;
                end
            end
            ST_REPLAY: begin
                // the replay byte is handled exactly as a fresh capture in EMPTY
                drop_s = cap_s;
                if (!rep_addr_r[0]) begin
                    held_from_rep_s = 1'b1;
                end else begin
                    push_s       = 1'b1;
                    push_entry_s = make_entry(rep_sel_r, rep_addr_r, {rep_byte_r, 8'h00}, 2'b10);
                end
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Holding (low byte) and replay registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_sel_r  <= 4'd0;
            held_addr_r <= 24'd0;
            held_byte_r <= 8'd0;
            rep_sel_r   <= 4'd0;
            rep_addr_r  <= 24'd0;
            rep_byte_r  <= 8'd0;
        end else begin
            if (held_from_in_s) begin
                held_sel_r  <= in_sel_s;
                held_addr_r <= in_addr_s;
                held_byte_r <= load_data;
            end else if (held_from_rep_s) begin
                held_sel_r  <= rep_sel_r;
                held_addr_r <= rep_addr_r;
                held_byte_r <= rep_byte_r;
            end else begin
                held_byte_r <= held_byte_r;
            end
            if (latch_rep_s) begin
                rep_sel_r  <= in_sel_s;
                rep_addr_r <= in_addr_s;
                rep_byte_r <= load_data;
            end else begin
                rep_byte_r <= rep_byte_r;
            end
        end
    end

    // FIFO status; the extra pointer bit tells full from empty.
    assign fifo_empty_s = (wptr_r == rptr_r);
    assign fifo_full_s  = (wptr_r[FIFO_AW] != rptr_r[FIFO_AW]) &&
                          (wptr_r[FIFO_AW-1:0] == rptr_r[FIFO_AW-1:0]);
    assign pop_s        = ~fifo_empty_s & mem_ack;
    // a pop in the same cycle frees the slot for the push
    assign push_ok_s    = push_s & (~fifo_full_s | pop_s);

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= {(FIFO_AW+1){1'b0}};
            rptr_r <= {(FIFO_AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {EW{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wptr_r[FIFO_AW-1:0]] <= push_entry_s;
                wptr_r <= wptr_r + PTR_ONE;
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end else begin
                rptr_r <= rptr_r;
            end
        end
    end

    // Sticky overflow and load-session tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
            session_r  <= 1'b0;
        end else begin
            if ((push_s && !push_ok_s) || drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (loading) begin
                session_r <= 1'b1;
            end else if (done_s) begin
                session_r <= 1'b0;
            end else begin
                session_r <= session_r;
            end
        end
    end

    assign done_s = session_r & ~loading & (state_r == ST_EMPTY) & fifo_empty_s;
    assign head_s = fifo_mem_r[rptr_r[FIFO_AW-1:0]];

    // Handshake outputs come straight from the registered FIFO head.
    assign mem_req   = ~fifo_empty_s;
    assign mem_sel   = head_s[44:41];
    assign mem_addr  = head_s[40:18];
    assign mem_wdata = head_s[17:2];
    assign mem_be    = head_s[1:0];
    assign hold      = loading | (state_r != ST_EMPTY) | ~fifo_empty_s;
    assign done      = done_s;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_uart_load_packer.sv
module tb_uart_load_packer;

    typedef struct packed {
        logic [3:0]  sel;
        logic [22:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] load_addr;
    logic        load_we;
    logic        loading;
    logic [7:0]  load_data;
    logic        mem_req;
    logic        mem_ack;
    logic [3:0]  mem_sel;
    logic [22:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        hold;
    logic        done;
    logic        overflow;

    uart_load_packer #(.FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .load_addr(load_addr), .load_we(load_we),
        .loading(loading), .load_data(load_data), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .hold(hold), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    int  done_cnt = 0;
    int  ack_mode = 1;   // 0 random, 1 always, 2 never
    wr_t sb[$];

    // reference model: an unpaired even byte waiting for its partner
    bit          m_has = 1'b0;
    logic [3:0]  m_sel;
    logic [23:0] m_addr;
    logic [7:0]  m_byte;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void exp_push(input logic [3:0] sel, input logic [23:0] a,
                                     input logic [15:0] d, input logic [1:0] be);
        wr_t w;
        w.sel  = sel;
        w.addr = a[23:1];
        w.data = d;
        w.be   = be;
        sb.push_back(w);
    endfunction

    // Bytes sharing sel and word address pair up; anything else is written alone.
    function automatic void model_byte(input logic [3:0] sel, input logic [23:0] a, input logic [7:0] d);
        if (m_has) begin
            m_has = 1'b0;
            if (sel == m_sel && a[0] && (a >> 1) == (m_addr >> 1)) begin
                exp_push(m_sel, m_addr, {d, m_byte}, 2'b11);
                return;
            end
            exp_push(m_sel, m_addr, {8'h00, m_byte}, 2'b01);
        end
        if (!a[0]) begin
            m_has  = 1'b1;
            m_sel  = sel;
            m_addr = a;
            m_byte = d;
        end else begin
            exp_push(sel, a, {d, 8'h00}, 2'b10);
        end
    endfunction

    task automatic write_byte(input logic [3:0] sel, input logic [23:0] a,
                              input logic [7:0] d, input int we_cycles);
        @(posedge clk); #1;
        load_addr = {sel, a};
        load_data = d;
        load_we   = 1'b1;
        model_byte(sel, a, d);
        repeat (we_cycles) @(posedge clk);
        #1 load_we = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic start_session();
        @(posedge clk); #1 loading = 1'b1;
    endtask

    task automatic end_session(input string name);
        int n;
        int d0;
        d0 = done_cnt;
        @(posedge clk); #1 loading = 1'b0;
        if (m_has) begin
            exp_push(m_sel, m_addr, {8'h00, m_byte}, 2'b01);
            m_has = 1'b0;
        end
        n = 0;
        while ((sb.size() != 0 || hold) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain"}, 64'(n < 500), 64'd1);
        @(posedge clk); #1;
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    // Arbiter model; in random mode it is forced to accept once a backlog builds.
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            1: mem_ack = 1'b1;
            2: mem_ack = 1'b0;
            default: mem_ack = (sb.size() >= 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
        endcase
    end

    // Monitor: compare every accepted write against the scoreboard head.
    logic        stall_q = 1'b0;
    logic [45:0] prev_out;
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stall_q) check("stable_while_stalled", {18'd0, mem_req, mem_sel, mem_addr, mem_wdata, mem_be}, {18'd0, prev_out});
            if (mem_req) check("hold_while_req", 64'(hold), 64'd1);
            if (mem_req && mem_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {19'd0, mem_sel, mem_addr, mem_wdata, mem_be}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("write", {19'd0, mem_sel, mem_addr, mem_wdata, mem_be}, {19'd0, e});
                end
            end
            stall_q  = mem_req & ~mem_ack;
            prev_out = {mem_req, mem_sel, mem_addr, mem_wdata, mem_be};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic [23:0] a;
        logic [23:0] prev_a;
        logic [3:0]  sel;
        rst = 1'b1; load_addr = 28'd0; load_we = 1'b0; loading = 1'b0;
        load_data = 8'd0; mem_ack = 1'b0;
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_hold", 64'(hold), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // T1 pairing
        ack_mode = 1;
        start_session();
        write_byte(4'd1, 24'h000010, 8'hAA, 1);
        write_byte(4'd1, 24'h000011, 8'hBB, 1);
        end_session("t1");

        // T2 trailing byte
        start_session();
        write_byte(4'd1, 24'h000020, 8'h11, 1);
        write_byte(4'd1, 24'h000021, 8'h22, 1);
        write_byte(4'd1, 24'h000022, 8'h33, 1);
        end_session("t2");

        // T3 discontinuity through REPLAY, plus a sel change at an adjacent address
        start_session();
        write_byte(4'd1, 24'h000040, 8'h5A, 1);
        write_byte(4'd1, 24'h000081, 8'hC3, 1);
        write_byte(4'd2, 24'h000050, 8'h01, 1);
        write_byte(4'd3, 24'h000051, 8'h02, 1);
        write_byte(4'd3, 24'hFFFFFF, 8'h77, 2);
        end_session("t3");

        // T6 held strobe
        start_session();
        write_byte(4'd1, 24'h000101, 8'h9E, 6);
        end_session("t6");

        // T4 backpressure: five single-byte words into a four-deep FIFO
        ack_mode = 2;
        start_session();
        for (int i = 0; i < 5; i++) begin
            write_byte(4'd2, 24'h000201 + 24'(2 * i), 8'(8'h30 + i), 1);
        end
        void'(sb.pop_back());
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_req_stalled", 64'(mem_req), 64'd1);
        ack_mode = 1;
        end_session("t4");
        check("t4_overflow_sticky", 64'(overflow), 64'd1);

        // T5 reset with HALF and two queued words
        ack_mode = 2;
        start_session();
        write_byte(4'd4, 24'h000301, 8'h01, 1);
        write_byte(4'd4, 24'h000303, 8'h02, 1);
        write_byte(4'd4, 24'h000304, 8'h03, 1);
        d0 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        loading = 1'b0;
        #1;
        check("t5_mem_req", 64'(mem_req), 64'd0);
        check("t5_hold", 64'(hold), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);
        sb.delete();
        m_has = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ack_mode = 1;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_req_after", 64'(mem_req), 64'd0);
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);

        // randomized sessions with random arbiter acceptance
        ack_mode = 0;
        for (int s = 0; s < 6; s++) begin
            start_session();
            prev_a = 24'd0;
            sel = 4'($urandom_range(0, 2));
            for (int k = 0; k < int'($urandom_range(4, 16)); k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = prev_a + 24'd1;
                end else if ($urandom_range(0, 7) == 0) begin
                    a = ($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'hFFFFFE;
                end else begin
                    a = 24'($urandom);
                end
                if ($urandom_range(0, 5) == 0) sel = 4'($urandom_range(0, 15));
                write_byte(sel, a, 8'($urandom), int'($urandom_range(1, 4)));
                prev_a = a;
            end
            end_session("rand");
        end
        check("rand_no_overflow", 64'(overflow), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
